// File: rtl/dtc_trig_pkg.sv
// Shared types and constants for the DTC trigger scheduler.
// Holds FSM/kind enums, frame bit levels and default guard lengths.
package dtc_trig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI1,
        ST_HI2,
        ST_LO,
        ST_GUARD
    } state_t;

    typedef enum logic {
        KIND_L0,
        KIND_L1
    } kind_t;

    localparam logic FRAME_HI = 1'b1;
    localparam logic FRAME_LO = 1'b0;

    // Decoder-side assertion lengths and the zero prefix it needs to rearm.
    localparam int DEC_L0_ASSERT = 10;
    localparam int DEC_L1_ASSERT = 2;
    localparam int PREFIX_ZEROS  = 2;

    // The L1 guard also has to cover the decoder's two-clock wait window.
    localparam int DEF_GUARD_L0 = DEC_L0_ASSERT + PREFIX_ZEROS;
    localparam int DEF_GUARD_L1 = 2 + DEC_L1_ASSERT + PREFIX_ZEROS;

    // Number of zero cycles after reset before the first frame can start.
    localparam int RESET_GUARD = 2;

endpackage

// File: rtl/dtc_trig_queue.sv
// Request queue: single-deep L0 flag plus saturating L1 counter.
// In: clkin, reset_n, l0_req, l1_req, l0_clr, l1_dec. Out: l0_flag, l1_pending, l0_drop, l1_ovf.
module dtc_trig_queue
    import dtc_trig_pkg::*;
#(
    parameter int L1_MAX = 4,
    parameter int CNT_W  = 4
) (
    input  logic             clkin,
    input  logic             reset_n,
    input  logic             l0_req,
    input  logic             l1_req,
    input  logic             l0_clr,
    input  logic             l1_dec,
    output logic             l0_flag,
    output logic [CNT_W-1:0] l1_pending,
    output logic             l0_drop,
    output logic             l1_ovf
);

    logic l1_full;

    assign l1_full = (l1_pending == CNT_W'(L1_MAX));

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            l0_flag    <= 1'b0;
            l1_pending <= '0;
            l0_drop    <= 1'b0;
            l1_ovf     <= 1'b0;
        end else begin
            // A request arriving on the clearing cycle re-arms the flag.
            l0_drop <= l0_req && l0_flag && !l0_clr;
            if (l0_req) begin
                l0_flag <= 1'b1;
            end else if (l0_clr) begin
                l0_flag <= 1'b0;
            end

            // Request plus decrement cancel out, so it never overflows.
            l1_ovf <= l1_req && !l1_dec && l1_full;
            if (l1_req && !l1_dec && !l1_full) begin
                l1_pending <= l1_pending + 1'b1;
            end else if (l1_dec && !l1_req) begin
                l1_pending <= l1_pending - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dtc_trig_sched.sv
// Trigger scheduler/serializer for the single-wire dtc_trig line.
// In: clkin, reset_n, en, l0_req, l1_req. Out: dtc_trig, busy, l0_sent, l1_sent, l0_drop, l1_ovf, l1_pending.
module dtc_trig_sched
    import dtc_trig_pkg::*;
#(
    parameter int GUARD_L0 = DEF_GUARD_L0,
    parameter int GUARD_L1 = DEF_GUARD_L1,
    parameter int L1_MAX   = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clkin,
    input  logic             reset_n,
    input  logic             en,
    input  logic             l0_req,
    input  logic             l1_req,
    output logic             dtc_trig,
    output logic             busy,
    output logic             l0_sent,
    output logic             l1_sent,
    output logic             l0_drop,
    output logic             l1_ovf,
    output logic [CNT_W-1:0] l1_pending
);

    state_t           state;
    kind_t            kind;
    logic [CNT_W-1:0] gcnt;
    logic             l0_flag;
    logic             l0_clr;
    logic             l1_dec;

    // The queue is retired on the LO cycle, together with the sent pulse.
    assign l0_clr = (state == ST_LO) && (kind == KIND_L0);
    assign l1_dec = (state == ST_LO) && (kind == KIND_L1);

    dtc_trig_queue #(
        .L1_MAX (L1_MAX),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clkin      (clkin),
        .reset_n    (reset_n),
        .l0_req     (l0_req),
        .l1_req     (l1_req),
        .l0_clr     (l0_clr),
        .l1_dec     (l1_dec),
        .l0_flag    (l0_flag),
        .l1_pending (l1_pending),
        .l0_drop    (l0_drop),
        .l1_ovf     (l1_ovf)
    );

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_GUARD;
            kind     <= KIND_L0;
            gcnt     <= CNT_W'(RESET_GUARD);
            dtc_trig <= FRAME_LO;
            busy     <= 1'b1;
            l0_sent  <= 1'b0;
            l1_sent  <= 1'b0;
        end else begin
            l0_sent <= 1'b0;
            l1_sent <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (en && l0_flag) begin
                        dtc_trig <= FRAME_HI;
                        kind     <= KIND_L0;
                        busy     <= 1'b1;
                        state    <= ST_HI1;
                    end else if (en && (l1_pending != '0)) begin
                        dtc_trig <= FRAME_HI;
                        kind     <= KIND_L1;
                        busy     <= 1'b1;
                        state    <= ST_HI1;
                    end else begin
                        dtc_trig <= FRAME_LO;
                    end
                end
                ST_HI1: begin
                    if (kind == KIND_L1) begin
                        dtc_trig <= FRAME_HI;
                        state    <= ST_HI2;
                    end else begin
                        dtc_trig <= FRAME_LO;
                        l0_sent  <= 1'b1;
                        state    <= ST_LO;
                    end
                end
                ST_HI2: begin
                    dtc_trig <= FRAME_LO;
                    l1_sent  <= 1'b1;
                    state    <= ST_LO;
                end
                ST_LO: begin
                    // LO counts as the first guard cycle.
                    dtc_trig <= FRAME_LO;
                    gcnt     <= (kind == KIND_L0) ? CNT_W'(GUARD_L0 - 1)
                                                  : CNT_W'(GUARD_L1 - 1);
                    state    <= ST_GUARD;
                end
                ST_GUARD: begin
                    dtc_trig <= FRAME_LO;
                    gcnt     <= gcnt - 1'b1;
                    if (gcnt == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    dtc_trig <= FRAME_LO;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtc_trig_sched.sv
// Randomised and directed bench for dtc_trig_sched.
// Compares every cycle against a frame-schedule reference model.
module tb_dtc_trig_sched;

    localparam int G0    = 12;
    localparam int G1    = 6;
    localparam int L1MAX = 4;

    logic       clkin;
    logic       reset_n;
    logic       en;
    logic       l0_req;
    logic       l1_req;
    logic       dtc_trig;
    logic       busy;
    logic       l0_sent;
    logic       l1_sent;
    logic       l0_drop;
    logic       l1_ovf;
    logic [3:0] l1_pending;

    dtc_trig_sched #(
        .GUARD_L0 (G0),
        .GUARD_L1 (G1),
        .L1_MAX   (L1MAX),
        .CNT_W    (4)
    ) dut (
        .clkin      (clkin),
        .reset_n    (reset_n),
        .en         (en),
        .l0_req     (l0_req),
        .l1_req     (l1_req),
        .dtc_trig   (dtc_trig),
        .busy       (busy),
        .l0_sent    (l0_sent),
        .l1_sent    (l1_sent),
        .l0_drop    (l0_drop),
        .l1_ovf     (l1_ovf),
        .l1_pending (l1_pending)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Model: queued expected {trig, busy, l0_sent, l1_sent} per edge.
    logic [3:0] sched_q[$];
    bit  m_l0;
    int  m_l1;
    int  edge_n;
    int  clr0_at;
    int  dec1_at;

    // Observed event counters.
    int  cnt_l0s, cnt_l1s, cnt_drop, cnt_ovf;
    int  run1, l1n_timer, l1n_low;
    int  zeros_since_rst;
    bit  seen_one;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sched_q.delete();
        sched_q.push_back(4'b0100);
        sched_q.push_back(4'b0000);
        m_l0    = 1'b0;
        m_l1    = 0;
        clr0_at = -1;
        dec1_at = -1;
        zeros_since_rst = 0;
        seen_one = 1'b0;
    endtask

    task automatic push_frame(input bit is_l1);
        int g;
        if (is_l1) begin
            sched_q.push_back(4'b1100);
            sched_q.push_back(4'b1100);
            sched_q.push_back(4'b0101);
            dec1_at = edge_n + 3;
            g = G1;
        end else begin
            sched_q.push_back(4'b1100);
            sched_q.push_back(4'b0110);
            clr0_at = edge_n + 2;
            g = G0;
        end
        for (int i = 0; i < g - 1; i++) sched_q.push_back(4'b0100);
        sched_q.push_back(4'b0000);
    endtask

    task automatic step(input bit e, input bit r0, input bit r1);
        bit clr0, dec1, drop, ovf;
        logic [3:0] o;
        en     = e;
        l0_req = r0;
        l1_req = r1;
        edge_n++;
        clr0 = (edge_n == clr0_at);
        dec1 = (edge_n == dec1_at);
        if (sched_q.size() == 0) begin
            if (e && m_l0)        push_frame(1'b0);
            else if (e && m_l1 > 0) push_frame(1'b1);
            else                  sched_q.push_back(4'b0000);
        end
        drop = r0 && m_l0 && !clr0;
        if (r0)        m_l0 = 1'b1;
        else if (clr0) m_l0 = 1'b0;
        ovf = r1 && !dec1 && (m_l1 == L1MAX);
        if (r1 && !dec1 && m_l1 < L1MAX) m_l1++;
        else if (dec1 && !r1)            m_l1--;
        o = sched_q.pop_front();
        @(posedge clkin);
        #1;
        chk("outs",
            32'({dtc_trig, busy, l0_sent, l1_sent, l0_drop, l1_ovf, l1_pending}),
            32'({o, drop, ovf, 4'(m_l1)}));
        cnt_l0s  += int'(l0_sent);
        cnt_l1s  += int'(l1_sent);
        cnt_drop += int'(l0_drop);
        cnt_ovf  += int'(l1_ovf);
        if (dtc_trig) seen_one = 1'b1;
        else if (!seen_one) zeros_since_rst++;
        // Minimal decoder: two ones then a zero means L1 for 2 clocks.
        if (l1n_timer > 0) begin
            l1n_low++;
            l1n_timer--;
        end
        if (dtc_trig) begin
            run1++;
        end else begin
            if (run1 == 2) l1n_timer = 2;
            run1 = 0;
        end
    endtask

    task automatic idle(input int n, input bit e);
        for (int i = 0; i < n; i++) step(e, 1'b0, 1'b0);
    endtask

    task automatic clr_counts();
        cnt_l0s = 0; cnt_l1s = 0; cnt_drop = 0; cnt_ovf = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b0; l0_req = 1'b0; l1_req = 1'b0;
        edge_n = 0; run1 = 0; l1n_timer = 0; l1n_low = 0;
        clr_counts();
        repeat (2) @(posedge clkin);
        #1;
        chk("rst_trig", 32'(dtc_trig), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_pend", 32'(l1_pending), 32'd0);
        chk("rst_pulses", 32'({l0_sent, l1_sent, l0_drop, l1_ovf}), 32'd0);
        #2 reset_n = 1'b1;
        model_reset();

        // L0 request at cycle 5.
        idle(4, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        idle(20, 1'b1);
        chk("l0_sent_cnt", 32'(cnt_l0s), 32'd1);

        // Single L1 while idle, with decoder assertion length.
        clr_counts();
        l1n_low = 0;
        step(1'b1, 1'b0, 1'b1);
        idle(12, 1'b1);
        chk("l1_sent_cnt", 32'(cnt_l1s), 32'd1);
        chk("dec_l1n_low", 32'(l1n_low), 32'd2);

        // Simultaneous L0 and L1.
        clr_counts();
        step(1'b1, 1'b1, 1'b1);
        idle(30, 1'b1);
        chk("both_l0", 32'(cnt_l0s), 32'd1);
        chk("both_l1", 32'(cnt_l1s), 32'd1);

        // Five L1 while disabled, then drain.
        clr_counts();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        chk("sat_pend", 32'(l1_pending), 32'd4);
        chk("sat_ovf", 32'(cnt_ovf), 32'd1);
        idle(5, 1'b0);
        idle(50, 1'b1);
        chk("drain_l1", 32'(cnt_l1s), 32'd4);

        // Second L0 during HI1 is dropped.
        clr_counts();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(20, 1'b1);
        chk("drop_cnt", 32'(cnt_drop), 32'd1);
        chk("drop_l0s", 32'(cnt_l0s), 32'd1);

        // Reset during HI2 of an L1 frame.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("hi2_line", 32'(dtc_trig), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_trig", 32'(dtc_trig), 32'd0);
        chk("arst_pend", 32'(l1_pending), 32'd0);
        repeat (2) @(posedge clkin);
        #3 reset_n = 1'b1;
        model_reset();
        step(1'b1, 1'b1, 1'b0);
        idle(20, 1'b1);
        chk("rst_gap", 32'(zeros_since_rst >= 2), 32'd1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 7) != 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 4) == 0);
        end
        idle(80, 1'b1);
        chk("final_pend", 32'(l1_pending), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dtc_trig_sched.md
Name: dtc_trig_sched

Overview:
- Scheduler and serializer that drives the single-wire dtc_trig line toward the FEE-side trigger decoder.
- Accepts L0 and L1 trigger requests from the SRU trigger logic and queues them (L0 single-deep, L1 counted).
- Issues one frame at a time, L0 before L1, and enforces the guard gaps the decoder needs to return to its idle-wait state.
- Sits between the SRU trigger interface and the DTC link output mux.

Parameters:
- GUARD_L0, 12, low cycles after an L0 frame; covers the decoder's 10-clock L0 assertion plus a 2-zero prefix.
- GUARD_L1, 6, low cycles after an L1 frame; covers the decoder's wait/assert window plus a 2-zero prefix.
- L1_MAX, 4, maximum queued L1 requests (1..15).
- CNT_W, 4, width of the L1 pending counter and the guard counter; must hold max(GUARD_L0, L1_MAX).

Ports:
- clkin  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  frame issue enable; sampled in IDLE only.
- l0_req  input  1  one-cycle L0 request pulse.
- l1_req  input  1  one-cycle L1 request pulse.
- dtc_trig  output  1  registered serial trigger line; idle low.
- busy  output  1  high when not in IDLE.
- l0_sent  output  1  one-cycle pulse on the cycle an L0 frame's trailing 0 is driven.
- l1_sent  output  1  one-cycle pulse on the cycle an L1 frame's trailing 0 is driven.
- l0_drop  output  1  one-cycle pulse when an L0 request is lost.
- l1_ovf  output  1  one-cycle pulse when an L1 request is lost.
- l1_pending  output  CNT_W  queued L1 count.

Behaviour:
- Reset (async assert, sync deassert by the caller):
  - dtc_trig=0, busy=1, all pulse outputs 0, l1_pending=0, l0 flag clear.
  - State is GUARD with count 2, giving two zero cycles before the first frame.
- Frame encoding, one bit per clkin, MSB first:
  - L0 frame is 1,0.
  - L1 frame is 1,1,0.
  - The line is 0 at all other times.
- States: IDLE, HI1, HI2, LO, GUARD.
- IDLE:
  - If en and the l0 flag is set: dtc_trig<=1, kind<=L0, go HI1.
  - Otherwise, if en and l1_pending>0: dtc_trig<=1, kind<=L1, go HI1.
  - Otherwise hold with dtc_trig=0.
- HI1:
  - If kind=L1: dtc_trig<=1, go HI2.
  - If kind=L0: dtc_trig<=0, go LO.
- HI2: dtc_trig<=0, go LO.
- LO:
  - dtc_trig held 0.
  - Pulse l0_sent or l1_sent (asserted together with the trailing-0 register update, i.e. in the cycle the line shows 0 after the 1s).
  - Clear the l0 flag or decrement l1_pending.
  - Load the guard counter with GUARD_L0-1 or GUARD_L1-1, then go GUARD.
- GUARD:
  - Decrement the counter each cycle; at 0 go IDLE.
  - Total low time after the last 1 is exactly GUARD_x cycles, counting the LO cycle.
- Latency: a request arriving while IDLE, en=1 and the queue is empty drives the first 1 on the edge after the request is registered, i.e. 2 edges after the request edge.
- L0 queue:
  - l0_req while the flag is set and not being cleared that cycle: l0_drop pulse, request discarded.
  - l0_req in the LO cycle of an L0 frame is accepted; set wins over clear.
- L1 queue:
  - An l1_req and a decrement in the same cycle leave the count unchanged.
  - An l1_req with count=L1_MAX and no decrement: l1_ovf pulse, count unchanged.
- Priority: L0 over L1 only at the IDLE decision. A frame in progress is never pre-empted; a queued L0 waits for the current frame and its guard to finish.
- en=0 blocks only new frame starts. In-progress frames and guards complete normally, and requests keep queueing while disabled.
- Asserting reset_n low mid-frame immediately forces dtc_trig=0 and clears both queues.

Decomposition:
- Package dtc_trig_pkg holds:
  - the state enum;
  - the kind enum (L0, L1);
  - the frame bit constants;
  - default guard values, shared with the decoder's 10-clock L0 and 2-clock L1 assertion constants.
- One sub-module, dtc_trig_queue, holds the l0 flag and the saturating l1 counter with drop/overflow pulses. The top holds the FSM, guard counter and serializer.

Test Plan:
- Reset release, then l0_req at cycle 5 with en=1:
  - dtc_trig reads 1 then 0 at cycles 7 and 8, then 0 for 12 cycles.
  - l0_sent pulses at cycle 8; busy falls 12 cycles after the LO cycle.
- l1_req while idle:
  - line pattern 1,1,0 followed by 6 zeros, l1_sent once, l1_pending 1→0.
  - A decoder model fed with this line asserts trig_l1n low for 2 clocks.
- l0_req and l1_req in the same cycle: L0 frame first, 12-cycle guard, then the L1 frame; both sent pulses fire once.
- Five l1_req pulses while en=0:
  - l1_pending saturates at 4 with one l1_ovf.
  - Raising en produces 4 L1 frames, each separated by the 6-cycle guard.
- Second l0_req during an L0 frame's HI1 cycle: l0_drop pulses and only one L0 frame is emitted.
- reset_n low during HI2 of an L1 frame:
  - dtc_trig goes 0 asynchronously and l1_pending reads 0.
  - After release the line stays low for at least 2 cycles before any new frame.
